// File: rtl/fmap_feeder.sv
// ============================================================================
// Module   : fmap_feeder
// Purpose  : Streams feature-map words from global-buffer SRAM through a
//            2-entry skid into the PE fmap FIFO, sequencing the pad loader.
// Options  : FMAP_FEEDER_STALL_CNT_EN adds the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_feeder #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDRESSWIDTH_F_PAD = 8,
    parameter int GB_ADDR_WIDTH      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_full_column,
    input  logic [GB_ADDR_WIDTH-1:0]      cfg_base_addr,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] cfg_pixel_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] cfg_column_num,
    output logic                          gb_rd_en,
    output logic [GB_ADDR_WIDTH-1:0]      gb_rd_addr,
    input  logic [DATA_WIDTH-1:0]         gb_rd_data,
    input  logic                          fifo_full,
    output logic [DATA_WIDTH-1:0]         fmap_in,
    output logic                          fmap_in_en,
    output logic                          fmap_load_start,
    output logic                          load_full_cloumn,
    input  logic                          load_one_cloumn_finish,
    output logic                          busy,
    output logic                          done
`ifdef FMAP_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_STREAM   = 3'd2,
        S_WAIT_COL = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic                            r_full;
    logic [ADDRESSWIDTH_F_PAD-1:0]   r_col_num;
    logic [ADDRESSWIDTH_F_PAD-1:0]   r_remaining;
    logic [ADDRESSWIDTH_F_PAD-1:0]   r_col_len;
    logic [ADDRESSWIDTH_F_PAD-1:0]   r_issued;
    logic [ADDRESSWIDTH_F_PAD-1:0]   r_pushed;
    logic [GB_ADDR_WIDTH-1:0]        r_addr;
    logic                            r_inflight;
    logic [DATA_WIDTH-1:0]           r_skid_head;
    logic [DATA_WIDTH-1:0]           r_skid_tail;
    logic [1:0]                      r_skid_cnt;
    logic                            r_fin_latched;
    logic                            r_load_full;

    logic                            w_skid_nonempty;
    logic                            w_push;
    logic                            w_rd_en;
    logic                            w_last_push;
    logic                            w_finish;
    logic                            w_cfg_full;
    logic [ADDRESSWIDTH_F_PAD-1:0]   w_col_len_start;
    logic [2:0]                      w_occupancy;

    always_comb begin
        w_skid_nonempty = (r_skid_cnt != 2'd0);
        w_push          = w_skid_nonempty & ~fifo_full;
        // A word leaving the skid this cycle frees a slot for the read issued now.
        w_occupancy     = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_push};
        w_rd_en         = (r_state == S_STREAM) && (r_issued < r_col_len) && (w_occupancy < 3'd2);
        w_last_push     = (r_state == S_STREAM) && w_push && (r_pushed == r_col_len - 1'b1);
        w_finish        = load_one_cloumn_finish | r_fin_latched;
        w_cfg_full      = cfg_full_column | (cfg_column_num == '0);
        w_col_len_start = r_full ? r_remaining :
                          ((r_col_num < r_remaining) ? r_col_num : r_remaining);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        gb_rd_en         = w_rd_en;
        gb_rd_addr       = r_addr;
        fmap_in          = r_skid_head;
        fmap_in_en       = w_push;
        fmap_load_start  = 1'b0;
        load_full_cloumn = r_load_full;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next_state = (cfg_pixel_num == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                fmap_load_start = 1'b1;
                w_next_state    = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_push) begin
                    w_next_state = S_WAIT_COL;
                end
            end
            S_WAIT_COL: begin
                if (w_finish) begin
                    w_next_state = (r_remaining != '0) ? S_START : S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full        <= 1'b0;
            r_col_num     <= '0;
            r_remaining   <= '0;
            r_col_len     <= '0;
            r_issued      <= '0;
            r_pushed      <= '0;
            r_addr        <= '0;
            r_inflight    <= 1'b0;
            r_skid_head   <= '0;
            r_skid_tail   <= '0;
            r_skid_cnt    <= 2'd0;
            r_fin_latched <= 1'b0;
            r_load_full   <= 1'b1;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            case ({w_push, r_inflight})
                2'b01: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_skid_head <= gb_rd_data;
                    end else begin
                        r_skid_tail <= gb_rd_data;
                    end
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b10: begin
                    r_skid_head <= r_skid_tail;
                    r_skid_cnt  <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_skid_head <= gb_rd_data;
                    end else begin
                        r_skid_head <= r_skid_tail;
                        r_skid_tail <= gb_rd_data;
                    end
                end
                default: ;
            endcase
            if (w_push) begin
                r_pushed <= r_pushed + 1'b1;
            end
            if (w_last_push) begin
                r_fin_latched <= load_one_cloumn_finish;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_full      <= w_cfg_full;
                        r_col_num   <= cfg_column_num;
                        r_remaining <= cfg_pixel_num;
                        r_addr      <= cfg_base_addr;
                        if (cfg_pixel_num != '0) begin
                            r_load_full <= w_cfg_full;
                        end
                    end
                end
                S_START: begin
                    r_col_len     <= w_col_len_start;
                    r_remaining   <= r_remaining - w_col_len_start;
                    r_issued      <= '0;
                    r_pushed      <= '0;
                    r_fin_latched <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FMAP_FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == S_IDLE) && cfg_start) begin
            r_stall_cnt <= 16'd0;
        end else if (w_skid_nonempty && fifo_full && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
